// File: rtl/wb_pkg.sv
// Shared types and helpers for the Wishbone classic arbiter.
//   wb_arb_state_e : arbiter FSM states
//   wb_resp_t      : device response bundle {ack, err, rty}
//   rr_pick()      : round-robin pick over up to RR_MAX requesters
package wb_pkg;

    localparam int unsigned RR_MAX   = 16;
    localparam int unsigned RR_IDX_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANTED = 2'd1,
        ST_ABORT   = 2'd2
    } wb_arb_state_e;

    typedef struct packed {
        logic ack;
        logic err;
        logic rty;
    } wb_resp_t;

    // First set bit of req at or after ptr, wrapping at n; 0 when req is empty.
    function automatic logic [RR_IDX_W-1:0] rr_pick(
        input logic [RR_MAX-1:0]   req,
        input logic [RR_IDX_W-1:0] ptr,
        input int unsigned         n
    );
        logic [RR_IDX_W-1:0] pick;
        logic                found;
        int unsigned         idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < RR_MAX; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= n) begin
                idx = idx - n;
            end
            if (!found && (i < n) && req[RR_IDX_W'(idx)]) begin
                pick  = RR_IDX_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker.
//   req_i       : request vector
//   ptr_i       : highest-priority index this round
//   valid_o     : at least one request present
//   grant_oh_o  : one-hot winner (all zero when no request)
//   grant_idx_o : binary winner index
module rr_priority_picker
    import wb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               valid_o,
    output logic [NUM_REQ-1:0] grant_oh_o,
    output logic [IDX_W-1:0]   grant_idx_o
);

    logic [RR_IDX_W-1:0] pick;

    always_comb begin
        pick        = rr_pick(RR_MAX'(req_i), RR_IDX_W'(ptr_i), NUM_REQ);
        valid_o     = |req_i;
        grant_idx_o = IDX_W'(pick);
        grant_oh_o  = '0;
        if (valid_o) begin
            grant_oh_o[grant_idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/wb_classic_arbiter.sv
// Wishbone B4 classic arbiter: NUM_CTRL controllers share one device port.
// Round-robin grant held for the whole bus cycle; a watchdog aborts stalled
// transfers with err.
//   clk_i, rst_ni                         : clock, async active-low reset
//   c_cyc/stb/we/adr/sel/dat_i            : controller requests (flat arrays)
//   c_ack/err/rty_o                       : per-controller responses
//   c_dat_o                               : read data, broadcast
//   d_cyc/stb/we/adr/sel/dat_o            : device request
//   d_ack/err/rty/dat_i                   : device response
//   grant_o, busy_o                       : debug owner index, not-idle flag
module wb_classic_arbiter
    import wb_pkg::*;
#(
    parameter  int unsigned NUM_CTRL  = 4,
    parameter  int unsigned DAT_WIDTH = 32,
    parameter  int unsigned ADR_WIDTH = 16,
    parameter  int unsigned SEL_WIDTH = DAT_WIDTH / 8,
    parameter  int unsigned TIMEOUT   = 255,
    localparam int unsigned IDX_W     = $clog2(NUM_CTRL)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_CTRL-1:0]           c_cyc_i,
    input  logic [NUM_CTRL-1:0]           c_stb_i,
    input  logic [NUM_CTRL-1:0]           c_we_i,
    input  logic [NUM_CTRL*ADR_WIDTH-1:0] c_adr_i,
    input  logic [NUM_CTRL*SEL_WIDTH-1:0] c_sel_i,
    input  logic [NUM_CTRL*DAT_WIDTH-1:0] c_dat_i,
    output logic [NUM_CTRL-1:0]           c_ack_o,
    output logic [NUM_CTRL-1:0]           c_err_o,
    output logic [NUM_CTRL-1:0]           c_rty_o,
    output logic [DAT_WIDTH-1:0]          c_dat_o,
    output logic                          d_cyc_o,
    output logic                          d_stb_o,
    output logic                          d_we_o,
    output logic [ADR_WIDTH-1:0]          d_adr_o,
    output logic [SEL_WIDTH-1:0]          d_sel_o,
    output logic [DAT_WIDTH-1:0]          d_dat_o,
    input  logic                          d_ack_i,
    input  logic                          d_err_i,
    input  logic                          d_rty_i,
    input  logic [DAT_WIDTH-1:0]          d_dat_i,
    output logic [IDX_W-1:0]              grant_o,
    output logic                          busy_o
);

    localparam int unsigned WD_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    wb_arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]      grant_q, grant_d;
    logic [NUM_CTRL-1:0]   grant_oh_q, grant_oh_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [WD_W-1:0]       wd_cnt_q, wd_cnt_d;

    logic                  pick_valid;
    logic [NUM_CTRL-1:0]   pick_oh;
    logic [IDX_W-1:0]      pick_idx;

    wb_resp_t              d_resp;
    logic                  resp_any;

    logic                  sel_cyc, sel_stb, sel_we;
    logic [ADR_WIDTH-1:0]  sel_adr;
    logic [SEL_WIDTH-1:0]  sel_sel;
    logic [DAT_WIDTH-1:0]  sel_dat;

    rr_priority_picker #(
        .NUM_REQ (NUM_CTRL)
    ) u_picker (
        .req_i       (c_cyc_i),
        .ptr_i       (rr_ptr_q),
        .valid_o     (pick_valid),
        .grant_oh_o  (pick_oh),
        .grant_idx_o (pick_idx)
    );

    assign d_resp   = '{ack: d_ack_i, err: d_err_i, rty: d_rty_i};
    assign resp_any = d_resp.ack | d_resp.err | d_resp.rty;

    // Request fields of the current owner, selected by the one-hot grant.
    always_comb begin
        sel_cyc = 1'b0;
        sel_stb = 1'b0;
        sel_we  = 1'b0;
        sel_adr = '0;
        sel_sel = '0;
        sel_dat = '0;
        for (int i = 0; i < int'(NUM_CTRL); i++) begin
            if (grant_oh_q[i]) begin
                sel_cyc = c_cyc_i[i];
                sel_stb = c_stb_i[i];
                sel_we  = c_we_i[i];
                sel_adr = c_adr_i[i*ADR_WIDTH +: ADR_WIDTH];
                sel_sel = c_sel_i[i*SEL_WIDTH +: SEL_WIDTH];
                sel_dat = c_dat_i[i*DAT_WIDTH +: DAT_WIDTH];
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            grant_oh_q <= '0;
            rr_ptr_q   <= '0;
            wd_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_oh_q <= grant_oh_d;
            rr_ptr_q   <= rr_ptr_d;
            wd_cnt_q   <= wd_cnt_d;
        end
    end

    // Next state, watchdog and bus muxing.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_oh_d = grant_oh_q;
        rr_ptr_d   = rr_ptr_q;
        wd_cnt_d   = '0;

        d_cyc_o = 1'b0;
        d_stb_o = 1'b0;
        d_we_o  = 1'b0;
        d_adr_o = '0;
        d_sel_o = '0;
        d_dat_o = '0;
        c_ack_o = '0;
        c_err_o = '0;
        c_rty_o = '0;
        // Read data is broadcast; forced low only while reset is held.
        c_dat_o = rst_ni ? d_dat_i : '0;
        grant_o = grant_q;
        busy_o  = (state_q != ST_IDLE);

        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d    = pick_idx;
                    grant_oh_d = pick_oh;
                    rr_ptr_d   = (pick_idx == IDX_W'(NUM_CTRL - 1)) ? '0 : pick_idx + IDX_W'(1);
                    state_d    = ST_GRANTED;
                end
            end
            ST_GRANTED: begin
                d_cyc_o = sel_cyc;
                d_stb_o = sel_stb;
                d_we_o  = sel_we;
                d_adr_o = sel_adr;
                d_sel_o = sel_sel;
                d_dat_o = sel_dat;
                c_ack_o = grant_oh_q & {NUM_CTRL{d_resp.ack}};
                c_err_o = grant_oh_q & {NUM_CTRL{d_resp.err}};
                c_rty_o = grant_oh_q & {NUM_CTRL{d_resp.rty}};
                if (!sel_cyc) begin
                    state_d = ST_IDLE;
                end else if ((TIMEOUT != 0) && sel_stb && !resp_any) begin
                    // A response arriving on the last count still wins.
                    if (wd_cnt_q == WD_LAST) begin
                        state_d = ST_ABORT;
                    end else begin
                        wd_cnt_d = wd_cnt_q + WD_W'(1);
                    end
                end
            end
            ST_ABORT: begin
                // Device port idle; late device responses are dropped.
                c_err_o = grant_oh_q;
                state_d = sel_cyc ? ST_GRANTED : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
